svga_timing_gen: RTL and testbench
==================================

Name: svga_timing_gen

Overview:
- Free-running raster timing generator for the video pipeline; produces sync, blanking, data-enable and pixel coordinates.
- Drives the sprite/pixel stage that produces rrggbb and the board-level DVI output registers.
- Default timing is VESA 800x600@60 at a 40 MHz pixel clock (1056x628 total).
- All outputs are registered and mutually aligned to the same pixel position.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- H_SYNC_POL, 1, hsync active level (1 = active high)
- V_SYNC_POL, 1, vsync active level
- Derived (localparam): H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL)

Ports:
- clk, input, 1, pixel clock
- reset_n, input, 1, reset
- hcount, output, HW, current pixel column (0..H_TOTAL-1)
- vcount, output, VW, current line (0..V_TOTAL-1)
- hsync, output, 1, horizontal sync, polarity per H_SYNC_POL
- vsync, output, 1, vertical sync, polarity per V_SYNC_POL
- hblank, output, 1, high when hcount >= H_VISIBLE
- vblank, output, 1, high when vcount >= V_VISIBLE
- de, output, 1, data enable = !hblank && !vblank
- next_vertical, output, 1, one-cycle pulse on the last pixel of every line
- next_frame, output, 1, one-cycle pulse on the last pixel of the frame

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low; deassertion is synchronous to clk at the top level.
- Reset (async, immediate): hcount=0, vcount=0, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, hblank=0, vblank=0, de=1, next_vertical=0, next_frame=0.
  - These values are exactly the decode of position (0,0), so the reset state is self-consistent.
- Counting: hcount increments every clk.
  - At hcount==H_TOTAL-1: hcount wraps to 0 and vcount increments.
  - At hcount==H_TOTAL-1 and vcount==V_TOTAL-1: both wrap to 0.
  - No stall or enable input; the generator never stops.
- Registering: every status output is a flop loaded from the decode of the *next* (hcount,vcount). All outputs therefore describe the position currently shown on hcount/vcount. There is zero relative latency and no combinational paths to outputs.
- hsync region (active level): H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC. Default: 840..967.
- vsync region (active level): V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC. Default lines 601..604.
  - vsync changes only at hcount==0 boundaries.
- next_vertical: high exactly when hcount==H_TOTAL-1, on every line including blanking lines.
- next_frame: high exactly when hcount==H_TOTAL-1 && vcount==V_TOTAL-1. It coincides with a next_vertical pulse.
- Width rules: counters are unsigned. Compare and wrap use equality against H_TOTAL-1 / V_TOTAL-1, never overflow. Any parameter set with each term >=1 must work.
- Reset mid-frame: all outputs return to reset values immediately. Counting resumes from (0,0) on the first clk edge after release.

Test Plan:
- Reset release at default params:
  - Cycle 0 shows hcount=0, vcount=0, de=1, hsync=0, vsync=0.
  - de stays high for exactly 800 cycles, then low for 256.
- hsync timing: first hsync rising edge is 840 cycles after reset release; it stays high 128 cycles; period is 1056 cycles.
- Line/frame pulses:
  - next_vertical pulses once per 1056 cycles, first at hcount=1055.
  - next_frame pulses once per 663168 cycles, coincident with next_vertical at vcount=627.
  - A new frame starts the next cycle with de=1.
- Vertical timing:
  - vblank rises at the start of line 600.
  - vsync is high from (h=0,v=601) for exactly 4224 cycles.
  - vblank falls at wrap to line 0.
- Polarity and small params: H_VISIBLE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_*=3,1,1,1, H_SYNC_POL=0, V_SYNC_POL=0.
  - hsync is low only at hcount 5..6; line length is 8.
  - vsync is low only on line 4; frame length is 48 cycles.
  - Checker compares every output against a reference model each cycle for 3 frames.
- Mid-frame reset: assert reset_n at (h=500,v=300) asynchronously between edges.
  - Outputs take reset values before the next edge.
  - After release, counting restarts at (0,0) and matches the model.

Source files
------------

// File: rtl/svga_timing_gen.sv
// Free-running raster timing generator: pixel/line counters plus registered
// sync, blanking, data-enable and end-of-line/end-of-frame strobes.
module svga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned H_FRONT    = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BACK     = 88,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_FRONT    = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BACK     = 23,
  parameter int unsigned H_SYNC_POL = 1,
  parameter int unsigned V_SYNC_POL = 1,
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW        = $clog2(H_TOTAL),
  localparam int unsigned VW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          next_vertical,
  output logic          next_frame
);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_BLANK_AT = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START   = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_BLANK_AT = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START   = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic          HS_ON      = 1'(H_SYNC_POL);
  localparam logic          VS_ON      = 1'(V_SYNC_POL);

  logic [HW-1:0] hcount_d, hcount_q;
  logic [VW-1:0] vcount_d, vcount_q;
  logic          hsync_d, hsync_q;
  logic          vsync_d, vsync_q;
  logic          hblank_d, hblank_q;
  logic          vblank_d, vblank_q;
  logic          de_d, de_q;
  logic          next_vertical_d, next_vertical_q;
  logic          next_frame_d, next_frame_q;

  // Advance the position, then decode status for the position being loaded
  // so every output register describes the same pixel as the counters.
  always_comb begin
    hcount_d = hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
    end

    hblank_d        = (hcount_d >= H_BLANK_AT);
    vblank_d        = (vcount_d >= V_BLANK_AT);
    de_d            = ~hblank_d & ~vblank_d;
    hsync_d         = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? HS_ON : ~HS_ON;
    vsync_d         = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? VS_ON : ~VS_ON;
    next_vertical_d = (hcount_d == H_LAST);
    next_frame_d    = next_vertical_d && (vcount_d == V_LAST);
  end

  // Reset values equal the decode of position (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q        <= '0;
      vcount_q        <= '0;
      hsync_q         <= ~HS_ON;
      vsync_q         <= ~VS_ON;
      hblank_q        <= 1'b0;
      vblank_q        <= 1'b0;
      de_q            <= 1'b1;
      next_vertical_q <= 1'b0;
      next_frame_q    <= 1'b0;
    end else begin
      hcount_q        <= hcount_d;
      vcount_q        <= vcount_d;
      hsync_q         <= hsync_d;
      vsync_q         <= vsync_d;
      hblank_q        <= hblank_d;
      vblank_q        <= vblank_d;
      de_q            <= de_d;
      next_vertical_q <= next_vertical_d;
      next_frame_q    <= next_frame_d;
    end
  end

  assign hcount        = hcount_q;
  assign vcount        = vcount_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign hblank        = hblank_q;
  assign vblank        = vblank_q;
  assign de            = de_q;
  assign next_vertical = next_vertical_q;
  assign next_frame    = next_frame_q;

endmodule

// File: tb/tb_svga_timing_gen.sv
// Bench for svga_timing_gen: three parameter sets checked every cycle against
// a position-from-cycle-count model, with random asynchronous resets.
module tb_svga_timing_gen;

  localparam int NCYC = 6000;

  // default 800x600 timing
  localparam int DHW = $clog2(1056);
  localparam int DVW = $clog2(628);
  // tiny timing, active-low syncs
  localparam int SHW = $clog2(8);
  localparam int SVW = $clog2(6);
  // medium timing, mixed polarity
  localparam int MHW = $clog2(25);
  localparam int MVW = $clog2(16);

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic hs, vs, hb, vb, de, nv, nf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0, rst_s = 1'b0, rst_m = 1'b0;
  int   hold_d = 3, hold_s = 3, hold_m = 3;
  int   n_d = 0, n_s = 0, n_m = 0;

  logic [DHW-1:0] d_h; logic [DVW-1:0] d_v;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_nv, d_nf;
  logic [SHW-1:0] s_h; logic [SVW-1:0] s_v;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_nv, s_nf;
  logic [MHW-1:0] m_h; logic [MVW-1:0] m_v;
  logic m_hs, m_vs, m_hb, m_vb, m_de, m_nv, m_nf;

  int total = 0;
  int bad   = 0;

  logic [2199:0] de_rec = '0, hs_rec = '0, nv_rec = '0;

  svga_timing_gen u_dflt (
    .clk(clk), .reset_n(rst_d), .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .hblank(d_hb), .vblank(d_vb), .de(d_de), .next_vertical(d_nv), .next_frame(d_nf));

  svga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0)
  ) u_small (
    .clk(clk), .reset_n(rst_s), .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .hblank(s_hb), .vblank(s_vb), .de(s_de), .next_vertical(s_nv), .next_frame(s_nf));

  svga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1), .V_SYNC_POL(0)
  ) u_mid (
    .clk(clk), .reset_n(rst_m), .hcount(m_h), .vcount(m_v), .hsync(m_hs), .vsync(m_vs),
    .hblank(m_hb), .vblank(m_vb), .de(m_de), .next_vertical(m_nv), .next_frame(m_nf));

  // Cycles elapsed since each instance left reset (zero while held in reset).
  always @(posedge clk or negedge rst_d) if (!rst_d) n_d <= 0; else n_d <= n_d + 1;
  always @(posedge clk or negedge rst_s) if (!rst_s) n_s <= 0; else n_s <= n_s + 1;
  always @(posedge clk or negedge rst_m) if (!rst_m) n_m <= 0; else n_m <= n_m + 1;

  // Raster position is the cycle count modulo frame size; status follows from it.
  function automatic exp_t model(input int hv, hf, hsw, hbk, vv, vf, vsw, vbk, hp, vp, n);
    exp_t e;
    int ht, vt, pos, h, v;
    ht  = hv + hf + hsw + hbk;
    vt  = vv + vf + vsw + vbk;
    pos = n % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    e.h  = 32'(h);
    e.v  = 32'(v);
    e.hb = (h >= hv);
    e.vb = (v >= vv);
    e.de = (h < hv) && (v < vv);
    e.hs = (h >= hv + hf && h < hv + hf + hsw) ? 1'(hp) : ~1'(hp);
    e.vs = (v >= vv + vf && v < vv + vf + vsw) ? 1'(vp) : ~1'(vp);
    e.nv = (h == ht - 1);
    e.nf = (h == ht - 1) && (v == vt - 1);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_inst(input string p, input exp_t e, input logic [31:0] h, v,
                            input logic hs, vs, hb, vb, de, nv, nf);
    check({p, ".hcount"}, h, e.h);
    check({p, ".vcount"}, v, e.v);
    check({p, ".hsync"}, 32'(hs), 32'(e.hs));
    check({p, ".vsync"}, 32'(vs), 32'(e.vs));
    check({p, ".hblank"}, 32'(hb), 32'(e.hb));
    check({p, ".vblank"}, 32'(vb), 32'(e.vb));
    check({p, ".de"}, 32'(de), 32'(e.de));
    check({p, ".next_vertical"}, 32'(nv), 32'(e.nv));
    check({p, ".next_frame"}, 32'(nf), 32'(e.nf));
  endtask

  function automatic int find_val(input logic [2199:0] a, input logic val, input int from);
    for (int i = from; i < 2200; i++) if (a[i] == val) return i;
    return -1;
  endfunction

  initial begin
    int r0, r1, f0, f1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #2;
      // Random asynchronous reset pulses, mid-cycle, once the early windows are covered.
      if (cyc > 3000 && hold_d == 0 && $urandom_range(0, 299) == 0) begin
        rst_d = 1'b0; hold_d = int'($urandom_range(1, 3));
      end
      if (cyc > 200 && hold_s == 0 && $urandom_range(0, 99) == 0) begin
        rst_s = 1'b0; hold_s = int'($urandom_range(1, 3));
      end
      if (cyc > 1500 && hold_m == 0 && $urandom_range(0, 199) == 0) begin
        rst_m = 1'b0; hold_m = int'($urandom_range(1, 3));
      end

      @(negedge clk);
      #1;
      check_inst("dflt", model(800, 40, 128, 88, 600, 1, 4, 23, 1, 1, n_d),
                 32'(d_h), 32'(d_v), d_hs, d_vs, d_hb, d_vb, d_de, d_nv, d_nf);
      check_inst("small", model(4, 1, 2, 1, 3, 1, 1, 1, 0, 0, n_s),
                 32'(s_h), 32'(s_v), s_hs, s_vs, s_hb, s_vb, s_de, s_nv, s_nf);
      check_inst("mid", model(16, 2, 4, 3, 10, 1, 2, 3, 1, 0, n_m),
                 32'(m_h), 32'(m_v), m_hs, m_vs, m_hb, m_vb, m_de, m_nv, m_nf);
      if (cyc < 2300 && n_d < 2200) begin
        de_rec[n_d] = d_de;
        hs_rec[n_d] = d_hs;
        nv_rec[n_d] = d_nv;
      end

      #2;
      if (hold_d > 0) begin hold_d--; if (hold_d == 0) rst_d = 1'b1; end
      if (hold_s > 0) begin hold_s--; if (hold_s == 0) rst_s = 1'b1; end
      if (hold_m > 0) begin hold_m--; if (hold_m == 0) rst_m = 1'b1; end
    end

    // Default-timing edge positions measured from the first reset release.
    f0 = find_val(de_rec, 1'b0, 0);
    check("dflt.de_high_len", 32'(f0), 32'd800);
    f1 = find_val(de_rec, 1'b1, (f0 < 0) ? 0 : f0);
    check("dflt.de_low_end", 32'(f1), 32'd1056);
    r0 = find_val(hs_rec, 1'b1, 0);
    check("dflt.hsync_rise", 32'(r0), 32'd840);
    f0 = find_val(hs_rec, 1'b0, (r0 < 0) ? 0 : r0);
    check("dflt.hsync_fall", 32'(f0), 32'd968);
    r1 = find_val(hs_rec, 1'b1, (f0 < 0) ? 0 : f0);
    check("dflt.hsync_period", 32'(r1 - r0), 32'd1056);
    r0 = find_val(nv_rec, 1'b1, 0);
    check("dflt.nv_first", 32'(r0), 32'd1055);
    r1 = find_val(nv_rec, 1'b1, (r0 < 0) ? 0 : r0 + 1);
    check("dflt.nv_second", 32'(r1), 32'd2111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
